// File: rtl/sequence_playback_ctrl_if.sv
// Playback controller bus: game FSM control,
// sequence memory read port and LED outputs.
interface sequence_playback_ctrl_if #(
  parameter int COLOR_CODEFY_W = 2,
  parameter int ADDR_WIDTH     = 5
);
  logic                      start;
  logic                      abort;
  logic                      speed;
  logic [ADDR_WIDTH-1:0]     last_index;
  logic [COLOR_CODEFY_W-1:0] sequence_item;
  logic                      mem_rd;
  logic [ADDR_WIDTH-1:0]     addr;
  logic                      led_red;
  logic                      led_green;
  logic                      led_blue;
  logic                      led_yellow;
  logic                      busy;
  logic                      done;

  modport master (
    output start, abort, speed,
    output last_index, sequence_item,
    input  mem_rd, addr,
    input  led_red, led_green,
    input  led_blue, led_yellow,
    input  busy, done
  );

  modport slave (
    input  start, abort, speed,
    input  last_index, sequence_item,
    output mem_rd, addr,
    output led_red, led_green,
    output led_blue, led_yellow,
    output busy, done
  );
endinterface

// File: rtl/sequence_playback_ctrl.sv
// Genius sequence playback: reads entries 0..last
// and lights each color for an on-time plus a gap.
module sequence_playback_ctrl #(
  parameter int COLOR_CODEFY_W = 2,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMER_W        = 26,
  parameter int ON_FAST        = 12_500_000,
  parameter int GAP_FAST       = 6_250_000,
  parameter int ON_SLOW        = 25_000_000,
  parameter int GAP_SLOW       = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  sequence_playback_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    ON,
    GAP,
    DONE
  } state_t;

  localparam logic [TIMER_W-1:0] ON_F_LD =
    TIMER_W'(ON_FAST - 1);
  localparam logic [TIMER_W-1:0] GAP_F_LD =
    TIMER_W'(GAP_FAST - 1);
  localparam logic [TIMER_W-1:0] ON_S_LD =
    TIMER_W'(ON_SLOW - 1);
  localparam logic [TIMER_W-1:0] GAP_S_LD =
    TIMER_W'(GAP_SLOW - 1);

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     idx;
  logic [ADDR_WIDTH-1:0]     last_q;
  logic                      speed_q;
  logic [COLOR_CODEFY_W-1:0] item_q;
  logic [TIMER_W-1:0]        timer;
  logic                      mem_rd_q;
  logic                      busy_q;
  logic                      done_q;
  logic [TIMER_W-1:0]        on_ld;
  logic [TIMER_W-1:0]        gap_ld;
  logic                      lit;

  assign on_ld  = speed_q ? ON_F_LD : ON_S_LD;
  assign gap_ld = speed_q ? GAP_F_LD : GAP_S_LD;

  // Playback sequencer; strobes registered with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      last_q   <= '0;
      speed_q  <= 1'b0;
      item_q   <= '0;
      timer    <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.abort) begin
      state    <= IDLE;
      idx      <= '0;
      timer    <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= READ;
            idx      <= '0;
            last_q   <= bus.last_index;
            speed_q  <= bus.speed;
            mem_rd_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        READ: begin
          state    <= LATCH;
          mem_rd_q <= 1'b0;
        end
        LATCH: begin
          item_q <= bus.sequence_item;
          timer  <= on_ld;
          state  <= ON;
        end
        ON: begin
          if (timer == '0) begin
            timer <= gap_ld;
            state <= GAP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        GAP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (idx == last_q) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            idx      <= idx + 1'b1;
            state    <= READ;
            mem_rd_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign lit = (state == ON);

  assign bus.mem_rd     = mem_rd_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.addr       = busy_q ? idx : '0;
  assign bus.led_red    = lit && (item_q == 2'd0);
  assign bus.led_green  = lit && (item_q == 2'd1);
  assign bus.led_blue   = lit && (item_q == 2'd2);
  assign bus.led_yellow = lit && (item_q == 2'd3);

endmodule

// File: tb/tb_sequence_playback_ctrl.sv
// Bench for sequence_playback_ctrl: timeline
// reference model plus directed/random playbacks.
module tb_sequence_playback_ctrl;

  localparam int AW  = 5;
  localparam int CW  = 2;
  localparam int TW  = 8;
  localparam int ONF = 3;
  localparam int GPF = 2;
  localparam int ONS = 6;
  localparam int GPS = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sequence_playback_ctrl_if #(
    .COLOR_CODEFY_W(CW),
    .ADDR_WIDTH(AW)
  ) bus ();

  sequence_playback_ctrl #(
    .COLOR_CODEFY_W(CW),
    .ADDR_WIDTH(AW),
    .TIMER_W(TW),
    .ON_FAST(ONF),
    .GAP_FAST(GPF),
    .ON_SLOW(ONS),
    .GAP_SLOW(GPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [CW-1:0] mem [2**AW];

  always @(posedge clk)
    if (bus.mem_rd) bus.sequence_item <= mem[bus.addr];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model: playback = timeline from accept edge
  bit act   = 0;
  int n_acc = 0;
  bit m_spd = 0;
  int m_last = 0;
  int t0    = 0;

  int n_done, n_rd, n_pulse, n_on, max_addr;
  int done_cyc, idle_cyc;
  logic [3:0] led_prev = '0;
  int colors[$];

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int per_of(bit s);
    return s ? (2 + ONF + GPF) : (2 + ONS + GPS);
  endfunction

  function automatic int on_of(bit s);
    return s ? ONF : ONS;
  endfunction

  task automatic model_edge();
    int kp;
    if (rst || bus.abort) begin
      act = 0;
    end else if (act) begin
      kp = cyc - n_acc;
      if (kp == (m_last + 1) * per_of(m_spd) + 1)
        act = 0;
    end else if (bus.start) begin
      act    = 1;
      n_acc  = cyc;
      m_spd  = bus.speed;
      m_last = int'(bus.last_index);
    end
  endtask

  function automatic logic [11:0] exp_out();
    logic       rd, b, d;
    logic [4:0] a;
    logic [3:0] l;
    int k, per, e, p;
    rd = 0; b = 0; d = 0; a = '0; l = '0;
    if (act) begin
      k   = cyc - n_acc + 1;
      per = per_of(m_spd);
      b   = 1;
      if (k == (m_last + 1) * per + 1) begin
        d = 1;
        a = AW'(m_last);
      end else begin
        e  = (k - 1) / per;
        p  = (k - 1) % per;
        a  = AW'(e);
        rd = (p == 0);
        if (p >= 2 && p < 2 + on_of(m_spd))
          l = 4'b0001 << mem[e];
      end
    end
    return {rd, a, l, b, d};
  endfunction

  task automatic step();
    logic [11:0] obs;
    logic [3:0]  led;
    int c;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    led = {bus.led_yellow, bus.led_blue,
           bus.led_green, bus.led_red};
    obs = {bus.mem_rd, bus.addr, led,
           bus.busy, bus.done};
    check("outs", 32'(obs), 32'(exp_out()));
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (!bus.busy && idle_cyc < 0) idle_cyc = cyc;
    if (bus.mem_rd) n_rd++;
    if (led != 0) n_on++;
    if (led != 0 && led_prev == 0) begin
      n_pulse++;
      c = 0;
      for (int b = 0; b < 4; b++)
        if (led[b]) c = b;
      colors.push_back(c);
    end
    led_prev = led;
    if (int'(bus.addr) > max_addr)
      max_addr = int'(bus.addr);
  endtask

  task automatic clr();
    n_done = 0; n_rd = 0; n_pulse = 0;
    n_on = 0; max_addr = 0;
    done_cyc = -1; idle_cyc = -1;
    colors.delete();
  endtask

  // start, then run until model returns idle
  task automatic play(bit sp, int li,
                      bit noise, int abort_k);
    clr();
    bus.speed      = sp;
    bus.last_index = AW'(li);
    bus.start      = 1;
    bus.abort      = 0;
    step();
    t0 = n_acc - 1;
    bus.start = 0;
    for (int i = 0; i < 2000 && act; i++) begin
      if (noise) begin
        bus.speed      = 1'($urandom);
        bus.last_index = AW'($urandom);
        bus.start      = 1'($urandom);
      end
      bus.abort = (abort_k > 0 &&
                   cyc - t0 == abort_k);
      step();
      if (act) idle_cyc = -1;
    end
    check("play_end", 32'(act), 0);
    bus.abort = 0;
    bus.start = 0;
  endtask

  initial begin
    int fc[3];
    int ak;
    fc = '{0, 3, 2};
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    rst = 1;
    bus.start = 0;
    bus.abort = 0;
    bus.speed = 0;
    bus.last_index = '0;
    bus.sequence_item = '0;
    clr();
    step();
    step();
    rst = 0;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_addr", 32'(bus.addr), 0);
    step();

    mem[0] = 2'd0; mem[1] = 2'd3; mem[2] = 2'd2;
    play(1, 2, 0, 0);
    check("fast_rd", n_rd, 3);
    check("fast_done_n", n_done, 1);
    check("fast_done_t", done_cyc - t0, 22);
    check("fast_pulses", n_pulse, 3);
    check("fast_on", n_on, 9);
    for (int i = 0; i < 3; i++)
      check("fast_color", colors[i], fc[i]);

    mem[0] = 2'd1;
    play(0, 0, 0, 0);
    check("slow_on", n_on, 6);
    check("slow_color", colors[0], 1);
    check("slow_done_t", done_cyc - t0, 13);
    check("slow_idle_t", idle_cyc - t0, 14);

    mem[0] = 2'd0;
    play(1, 2, 1, 0);
    check("iso_done_n", n_done, 1);
    check("iso_done_t", done_cyc - t0, 22);
    check("iso_pulses", n_pulse, 3);
    step();
    check("iso_no_rerun", 32'(bus.busy), 0);

    play(1, 2, 0, 13);
    check("abort_done", n_done, 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_rd", 32'(bus.mem_rd), 0);

    bus.start = 1;
    bus.abort = 1;
    step();
    check("abort_start", 32'(bus.busy), 0);
    bus.start = 0;
    bus.abort = 0;
    step();

    bus.speed = 1;
    bus.last_index = AW'(2);
    bus.start = 1;
    step();
    bus.start = 0;
    step();
    step();
    check("mid_on_red", 32'(bus.led_red), 1);
    rst = 1;
    step();
    step();
    rst = 0;
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_led", 32'(bus.led_red), 0);
    play(1, 0, 0, 0);
    check("rst_restart", n_pulse, 1);

    for (int i = 0; i < 2**AW; i++)
      mem[i] = CW'(i % 4);
    play(1, 31, 0, 0);
    check("full_pulses", n_pulse, 32);
    check("full_max_addr", max_addr, 31);
    check("full_done", n_done, 1);
    for (int i = 0; i < 32; i++)
      check("full_color", colors[i], i % 4);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 2**AW; i++)
        mem[i] = CW'($urandom);
      ak = ($urandom_range(0, 1) == 1) ?
           int'($urandom_range(1, 30)) : 0;
      play(1'($urandom), int'($urandom_range(0, 4)),
           1'($urandom), ak);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
